wb_stage_mlane: RTL and testbench

- Parametrised writeback stage for a LANES-wide issue pipeline. Sits between MEM and the regfile/hilo write ports.
- Latches the MEM→WB bundle under the existing 6-bit stall bus, and adds flush.
- Drives the per-lane regfile and hilo writes, with same-cycle write-conflict resolution.
- Serialises retired writes through a trace FIFO onto the single-write debug interface. Raises a stall request before that FIFO can overflow.

---
 rtl/wb_stage_mlane.sv | 188 ++++++++++++++++++
 tb/tb_wb_stage_mlane.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_mlane.sv
// Multi-lane writeback stage: latches the MEM->WB bundle, drives regfile/hilo writes with
// youngest-lane-wins conflict masking, and serialises retired writes onto the debug trace port.
module wb_stage_mlane #(
   parameter int LANES       = 2,
   parameter int TRACE_DEPTH = 8,
   parameter int AW          = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [5:0]            stall,
   input  logic                  flush,
   input  logic [LANES-1:0]      in_valid,
   input  logic [32*LANES-1:0]   in_pc,
   input  logic [LANES-1:0]      in_rf_we,
   input  logic [AW*LANES-1:0]   in_rf_waddr,
   input  logic [32*LANES-1:0]   in_rf_wdata,
   input  logic                  in_hi_we,
   input  logic                  in_lo_we,
   input  logic [31:0]           in_hi_data,
   input  logic [31:0]           in_lo_data,
   output logic [LANES-1:0]      rf_we,
   output logic [AW*LANES-1:0]   rf_waddr,
   output logic [32*LANES-1:0]   rf_wdata,
   output logic                  hi_we,
   output logic                  lo_we,
   output logic [31:0]           hi_data,
   output logic [31:0]           lo_data,
   output logic                  stallreq_wb,
   output logic                  trace_overflow,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
   localparam int CW = $clog2(TRACE_DEPTH + LANES + 1) + 1;

   typedef struct packed {
      logic [31:0]   pc;
      logic [AW-1:0] wnum;
      logic [31:0]   wdata;
   } trace_t;

   logic [LANES-1:0]    b_valid, b_we;
   logic [32*LANES-1:0] b_pc, b_wdata;
   logic [AW*LANES-1:0] b_waddr;
   logic                b_hi_we, b_lo_we;
   logic [31:0]         b_hi_data, b_lo_data;
   logic                new_b;

   logic                unused_stall_bits;
   assign unused_stall_bits = ^stall[3:0];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn || flush || (stall[4] && !stall[5])) begin
         b_valid   <= '0;
         b_we      <= '0;
         b_pc      <= '0;
         b_waddr   <= '0;
         b_wdata   <= '0;
         b_hi_we   <= 1'b0;
         b_lo_we   <= 1'b0;
         b_hi_data <= '0;
         b_lo_data <= '0;
         new_b     <= 1'b0;
      end else if (!stall[4]) begin
         b_valid   <= in_valid;
         b_we      <= in_rf_we;
         b_pc      <= in_pc;
         b_waddr   <= in_rf_waddr;
         b_wdata   <= in_rf_wdata;
         b_hi_we   <= in_hi_we;
         b_lo_we   <= in_lo_we;
         b_hi_data <= in_hi_data;
         b_lo_data <= in_lo_data;
         new_b     <= |in_valid;
      end else begin
         new_b     <= 1'b0;
      end
   end

   // cand marks retiring writes; rf_we additionally drops older lanes shadowed by a younger one.
   logic [LANES-1:0] cand;
   always_comb begin
      cand  = '0;
      rf_we = '0;
      for (int i = 0; i < LANES; i++)
         cand[i] = b_valid[i] & b_we[i] & (b_waddr[i*AW +: AW] != '0);
      for (int i = 0; i < LANES; i++) begin
         rf_we[i] = cand[i];
         for (int j = i + 1; j < LANES; j++)
            if (cand[j] && (b_waddr[j*AW +: AW] == b_waddr[i*AW +: AW]))
               rf_we[i] = 1'b0;
      end
   end

   assign rf_waddr = b_waddr;
   assign rf_wdata = b_wdata;
   assign hi_we    = b_hi_we & (|b_valid);
   assign lo_we    = b_lo_we & (|b_valid);
   assign hi_data  = b_hi_data;
   assign lo_data  = b_lo_data;

   trace_t          trace_mem [TRACE_DEPTH];
   logic [PW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;
   logic            pop;

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
      logic [CW-1:0] s;
      s = CW'(p) + n;
      if (s >= CW'(TRACE_DEPTH))
         s = s - CW'(TRACE_DEPTH);
      return PW'(s);
   endfunction

   logic [CW-1:0]   push_n, kept_n, space, next_fill;
   logic [LANES-1:0] keep;
   logic [PW-1:0]   slot [LANES];
   logic            drop;

   assign pop = (count != '0);

   // Candidates take consecutive slots in lane order; those beyond free space are dropped.
   always_comb begin
      push_n = '0;
      kept_n = '0;
      keep   = '0;
      drop   = 1'b0;
      space  = CW'(TRACE_DEPTH) - count + CW'(pop);
      for (int i = 0; i < LANES; i++) begin
         slot[i] = '0;
         if (new_b && cand[i]) begin
            push_n = push_n + CW'(1);
            if (kept_n < space) begin
               keep[i] = 1'b1;
               slot[i] = ptr_add(wptr, kept_n);
               kept_n  = kept_n + CW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   assign next_fill   = count + push_n - CW'(pop);
   assign stallreq_wb = next_fill > CW'(TRACE_DEPTH - LANES);

   // NOTE: the trace storage is deliberately not reset; count/pointers define which entries are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (keep[i])
            trace_mem[slot[i]] <= {b_pc[i*32 +: 32], b_waddr[i*AW +: AW], b_wdata[i*32 +: 32]};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr              <= '0;
         rptr              <= '0;
         count             <= '0;
         trace_overflow    <= 1'b0;
         debug_wb_pc       <= '0;
         debug_wb_rf_wen   <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         wptr  <= ptr_add(wptr, kept_n);
         count <= count + kept_n - CW'(pop);
         if (drop)
            trace_overflow <= 1'b1;
         if (pop) begin
            rptr              <= ptr_add(rptr, CW'(1));
            debug_wb_pc       <= trace_mem[rptr].pc;
            debug_wb_rf_wen   <= 4'hF;
            debug_wb_rf_wnum  <= 5'(trace_mem[rptr].wnum);
            debug_wb_rf_wdata <= trace_mem[rptr].wdata;
         end else begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Directed bench for wb_stage_mlane: a scoreboard queue holds expected trace entries in
// retirement order and a monitor pops/compares whenever the debug port shows a write.
module tb_wb_stage_mlane;

   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int AW    = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              resetn;
   logic [5:0]        stall;
   logic              flush;
   logic [LANES-1:0]  in_valid, in_rf_we;
   logic [63:0]       in_pc, in_rf_wdata;
   logic [9:0]        in_rf_waddr;
   logic              in_hi_we, in_lo_we;
   logic [31:0]       in_hi_data, in_lo_data;
   logic [LANES-1:0]  rf_we;
   logic [9:0]        rf_waddr;
   logic [63:0]       rf_wdata;
   logic              hi_we, lo_we;
   logic [31:0]       hi_data, lo_data;
   logic              stallreq_wb, trace_overflow;
   logic [31:0]       debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]        debug_wb_rf_wen;
   logic [4:0]        debug_wb_rf_wnum;

   wb_stage_mlane #(.LANES(LANES), .TRACE_DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_rf_we(in_rf_we),
      .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
      .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
      .in_hi_data(in_hi_data), .in_lo_data(in_lo_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi_we(hi_we), .lo_we(lo_we), .hi_data(hi_data), .lo_data(lo_data),
      .stallreq_wb(stallreq_wb), .trace_overflow(trace_overflow),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      in_valid    = '0;
      in_rf_we    = '0;
      in_rf_waddr = '0;
      in_rf_wdata = '0;
      in_pc       = '0;
      in_hi_we    = 1'b0;
      in_lo_we    = 1'b0;
      in_hi_data  = '0;
      in_lo_data  = '0;
   endtask

   // Applies a bundle; when it will be captured, queues its retiring lanes in lane order.
   task automatic drive(input logic [1:0] v, input logic [1:0] we,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input bit track);
      in_valid    = v;
      in_rf_we    = we;
      in_rf_waddr = {a1, a0};
      in_rf_wdata = {d1, d0};
      in_pc       = {p1, p0};
      if (track && resetn && !flush && !stall[4]) begin
         if (v[0] && we[0] && a0 != 5'd0) sb.push_back('{p0, a0, d0});
         if (v[1] && we[1] && a1 != 5'd0) sb.push_back('{p1, a1, d1});
      end
   endtask

   task automatic drain(input string tag, input int max_cycles);
      int n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         step();
         n++;
      end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && debug_wb_rf_wen !== 4'h0) begin
         check("trace_wen", debug_wb_rf_wen, 4'hF);
         check("trace_unexpected", 64'(sb.size() == 0), 64'd0);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("trace_pc", debug_wb_pc, mon_e.pc);
            check("trace_wnum", debug_wb_rf_wnum, mon_e.wnum);
            check("trace_wdata", debug_wb_rf_wdata, mon_e.wdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int  issued;
      int  cycles;
      bit  saw_req;

      resetn = 1'b0;
      stall  = '0;
      flush  = 1'b0;
      idle();
      repeat (2) step();
      check("rst_rf_we", rf_we, 2'b00);
      check("rst_dbg_wen", debug_wb_rf_wen, 4'h0);
      check("rst_dbg_pc", debug_wb_pc, 32'h0);
      check("rst_stallreq", stallreq_wb, 1'b0);
      check("rst_overflow", trace_overflow, 1'b0);
      check("rst_hi_we", hi_we, 1'b0);
      resetn = 1'b1;
      step();

      // Two-lane bundle with a hi write; checks zero-latency RF and N+2/N+3 trace latency.
      drive(2'b11, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 32'hBFC00000, 32'hBFC00004, 1);
      in_hi_we   = 1'b1;
      in_hi_data = 32'hCAFE0001;
      step();
      check("t1_rf_we", rf_we, 2'b11);
      check("t1_rf_waddr", rf_waddr, {5'd4, 5'd3});
      check("t1_rf_wdata", rf_wdata, 64'h00000022_00000011);
      check("t1_hi_we", hi_we, 1'b1);
      check("t1_hi_data", hi_data, 32'hCAFE0001);
      check("t1_lo_we", lo_we, 1'b0);
      check("t1_wen_n0", debug_wb_rf_wen, 4'h0);
      idle();
      step();
      check("t1_wen_n1", debug_wb_rf_wen, 4'h0);
      step();
      check("t1_pc_n2", debug_wb_pc, 32'hBFC00000);
      check("t1_wnum_n2", debug_wb_rf_wnum, 5'd3);
      check("t1_wdata_n2", debug_wb_rf_wdata, 32'h11);
      step();
      check("t1_pc_n3", debug_wb_pc, 32'hBFC00004);
      check("t1_wnum_n3", debug_wb_rf_wnum, 5'd4);
      step();
      check("t1_wen_n4", debug_wb_rf_wen, 4'h0);

      // Same-destination conflict: youngest lane keeps the RF write, trace keeps both.
      drive(2'b11, 2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 32'hBFC00010, 32'hBFC00014, 1);
      step();
      check("t2_rf_we", rf_we, 2'b10);
      check("t2_rf_wdata1", rf_wdata[63:32], 32'hB);
      idle();
      drain("t2_drain", 20);

      // Hold then bubble: held bundle keeps driving RF but retires to the trace only once.
      drive(2'b11, 2'b11, 5'd6, 5'd7, 32'h66, 32'h77, 32'hBFC00020, 32'hBFC00024, 1);
      step();
      idle();
      stall = 6'b110000;
      repeat (3) step();
      check("t3_hold_rf_we", rf_we, 2'b11);
      check("t3_hold_wdata", rf_wdata, 64'h00000077_00000066);
      stall = 6'b010000;
      step();
      check("t3_bubble_rf_we", rf_we, 2'b00);
      stall = 6'b000000;
      drain("t3_drain", 20);
      repeat (3) step();

      // Back-to-back full bundles with the controller honouring stallreq_wb.
      issued  = 0;
      cycles  = 0;
      saw_req = 1'b0;
      while (issued < 8 && cycles < 200) begin
         if (stallreq_wb) begin
            stall = 6'b010000;
            idle();
            step();
         end else begin
            stall = 6'b000000;
            drive(2'b11, 2'b11, 5'(1 + 2 * issued), 5'(2 + 2 * issued),
                  32'h100 + 32'(2 * issued), 32'h101 + 32'(2 * issued),
                  32'hBFC01000 + 32'(8 * issued), 32'hBFC01004 + 32'(8 * issued), 1);
            issued++;
            step();
            if (issued == 6)
               check("t4_stallreq_at_7", stallreq_wb, 1'b1);
         end
         saw_req |= stallreq_wb;
         cycles++;
      end
      check("t4_issued", 64'(issued), 64'd8);
      check("t4_saw_stallreq", saw_req, 1'b1);
      stall = 6'b000000;
      idle();
      drain("t4_drain", 60);
      check("t4_no_overflow", trace_overflow, 1'b0);
      repeat (2) step();

      // Flush with three entries queued: the flushed bundle never retires, the queue drains.
      drive(2'b11, 2'b11, 5'd10, 5'd11, 32'hA0, 32'hA1, 32'hBFC02000, 32'hBFC02004, 1);
      step();
      drive(2'b11, 2'b11, 5'd12, 5'd13, 32'hB0, 32'hB1, 32'hBFC02008, 32'hBFC0200C, 1);
      step();
      idle();
      step();
      flush = 1'b1;
      drive(2'b11, 2'b11, 5'd14, 5'd15, 32'hC0, 32'hC1, 32'hBFC02010, 32'hBFC02014, 1);
      step();
      check("t5_flush_rf_we", rf_we, 2'b00);
      flush = 1'b0;
      idle();
      drain("t5_drain", 20);
      repeat (2) step();

      // Reset in the middle of a drain.
      drive(2'b11, 2'b11, 5'd16, 5'd17, 32'hD0, 32'hD1, 32'hBFC03000, 32'hBFC03004, 1);
      step();
      drive(2'b11, 2'b11, 5'd18, 5'd19, 32'hE0, 32'hE1, 32'hBFC03008, 32'hBFC0300C, 1);
      step();
      idle();
      step();
      resetn = 1'b0;
      sb.delete();
      step();
      check("t5_rst_wen", debug_wb_rf_wen, 4'h0);
      check("t5_rst_rf_we", rf_we, 2'b00);
      check("t5_rst_stallreq", stallreq_wb, 1'b0);
      resetn = 1'b1;
      repeat (2) step();
      check("t5_rst_empty", debug_wb_rf_wen, 4'h0);

      // r0 destination and an invalid lane: no RF write, no trace entry.
      drive(2'b01, 2'b11, 5'd0, 5'd9, 32'h99, 32'h98, 32'hBFC04000, 32'hBFC04004, 1);
      step();
      check("t6_rf_we", rf_we, 2'b00);
      idle();
      repeat (2) step();
      check("t6_wen", debug_wb_rf_wen, 4'h0);

      // Non-compliant controller: ignore stallreq_wb until entries are dropped.
      mon_en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive(2'b11, 2'b11, 5'(20 + (k % 5)), 5'(25 + (k % 5)), 32'(k), 32'(k + 100),
               32'hBFC05000 + 32'(8 * k), 32'hBFC05004 + 32'(8 * k), 0);
         step();
      end
      idle();
      step();
      check("t7_overflow", trace_overflow, 1'b1);
      repeat (12) step();
      check("t7_overflow_sticky", trace_overflow, 1'b1);
      resetn = 1'b0;
      step();
      check("t7_rst_overflow", trace_overflow, 1'b0);
      check("t7_rst_wen", debug_wb_rf_wen, 4'h0);
      resetn = 1'b1;
      step();
      mon_en = 1'b1;
      repeat (2) step();

      check("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
